// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- multi-cycle ALU with start/busy/done handshake.
//
// Single-cycle ops (pass, add/sub with carry chaining, logic, zero-distance
// shifts, reserved codes) finish one clock after start. Shifts step one bit
// per cycle, multiply is a WIDTH-step shift-add, and the optional divider is a
// WIDTH-step restoring divide. Result and NZC flags are registered and only
// change on the cycle that enters FIN (done) or on reset.
//
// Configuration macro: SEQ_ALU_DIV_EN -- when defined, ops 16/17 are an
// iterative unsigned DIV/MOD; when undefined they behave as reserved codes and
// no divider logic exists.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset; aborts any op in progress
//   start     begin an op; only sampled in IDLE
//   op[4:0]   operation code, latched at start
//   a, b      operands, latched at start
//   busy      high while an iterative op is stepping (RUN)
//   done      one-cycle pulse; result/flags valid from this cycle
//   result    registered result
//   carry     registered C flag
//   zero      registered Z flag (result == 0)
//   negative  registered N flag (result MSB)
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = AW + 1;

  localparam logic [4:0] OP_PASSA = 5'd0;
  localparam logic [4:0] OP_PASSB = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_ADC   = 5'd3;
  localparam logic [4:0] OP_SUB   = 5'd4;
  localparam logic [4:0] OP_SBC   = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_OR    = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_NOTA  = 5'd9;
  localparam logic [4:0] OP_SHL   = 5'd10;
  localparam logic [4:0] OP_SHR   = 5'd11;
  localparam logic [4:0] OP_ASR   = 5'd12;
  localparam logic [4:0] OP_ROL   = 5'd13;
  localparam logic [4:0] OP_MULLO = 5'd14;
  localparam logic [4:0] OP_MULHI = 5'd15;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [4:0] OP_DIV   = 5'd16;
  localparam logic [4:0] OP_MOD   = 5'd17;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state, state_nxt;
  logic [4:0]           op_q;
  logic [WIDTH-1:0]     opnd_q;     // multiplicand (MUL) or divisor (DIV/MOD)
  logic [2*WIDTH-1:0]   work;       // shift value / {hi,lo} product / {rem,quot}
  logic [CW-1:0]        cnt;

  logic                 load, wr_sc, wr_it;
  logic                 is_shift, is_mul, iter;
  logic [AW-1:0]        amt;

  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c;
  logic [WIDTH:0]       sum_ext;

  logic [2*WIDTH-1:0]   step_work;
  logic                 step_c;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     it_res;
  logic                 it_c;
  logic [WIDTH-1:0]     fin_res;
  logic                 fin_c;

  assign amt      = b[AW-1:0];
  assign is_shift = op inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL};
  assign is_mul   = op inside {OP_MULLO, OP_MULHI};

  // A zero-distance shift has nothing to step, so it completes like any
  // single-cycle op.
`ifdef SEQ_ALU_DIV_EN
  assign iter = (is_shift && amt != '0) || is_mul || (op == OP_DIV) || (op == OP_MOD);
`else
  assign iter = (is_shift && amt != '0) || is_mul;
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs while in IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sc_res  = '0;
    sc_c    = 1'b0;
    sum_ext = '0;
    case (op)
      OP_PASSA: sc_res = a;
      OP_PASSB: sc_res = b;
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        {sc_c, sc_res} = sum_ext;
      end
      OP_ADC: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
        {sc_c, sc_res} = sum_ext;
      end
      // The extra top bit of the extended difference is the borrow.
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b};
        {sc_c, sc_res} = sum_ext;
      end
      OP_SBC: begin
        sum_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry};
        {sc_c, sc_res} = sum_ext;
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOTA: sc_res = ~a;
      OP_SHL, OP_SHR, OP_ASR, OP_ROL: sc_res = a;
      default: sc_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative step: one shift bit, one shift-add, or one restoring-divide bit.
  // ---------------------------------------------------------------------------
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_work;

  // Remainder lives in the upper half, quotient (seeded with the dividend)
  // in the lower half. A non-negative trial difference means the divisor fits.
  always_comb begin
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    div_work  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 work[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    step_work = work;
    step_c    = 1'b0;
    mul_sum   = '0;
    case (op_q)
      OP_SHL: begin
        step_c               = work[WIDTH-1];
        step_work[WIDTH-1:0] = {work[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        step_c               = work[0];
        step_work[WIDTH-1:0] = {1'b0, work[WIDTH-1:1]};
      end
      OP_ASR: begin
        step_c               = work[0];
        step_work[WIDTH-1:0] = {work[WIDTH-1], work[WIDTH-1:1]};
      end
      OP_ROL: begin
        step_c               = work[WIDTH-1];
        step_work[WIDTH-1:0] = {work[WIDTH-2:0], work[WIDTH-1]};
      end
      // Multiplier sits in the low half and drains out LSB first while the
      // partial product grows into the high half.
      OP_MULLO, OP_MULHI: begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{work[0]}}};
        step_work = {mul_sum, work[WIDTH-1:1]};
      end
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_MOD: step_work = div_work;
`endif
      default: step_work = work;
    endcase
  end

  // Result selection for the final step (written on the edge entering FIN).
  always_comb begin
    it_res = step_work[WIDTH-1:0];
    it_c   = step_c;
    case (op_q)
      OP_MULLO: it_c = |step_work[2*WIDTH-1:WIDTH];
      OP_MULHI: begin
        it_res = step_work[2*WIDTH-1:WIDTH];
        it_c   = 1'b0;
      end
`ifdef SEQ_ALU_DIV_EN
      // Divide by zero falls out of the restoring loop as all-ones / a;
      // only the error flag needs adding.
      OP_DIV: it_c = (opnd_q == '0);
      OP_MOD: begin
        it_res = step_work[2*WIDTH-1:WIDTH];
        it_c   = (opnd_q == '0);
      end
`endif
      default: ;
    endcase
  end

  assign fin_res = wr_it ? it_res : sc_res;
  assign fin_c   = wr_it ? it_c   : sc_c;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    wr_sc     = 1'b0;
    wr_it     = 1'b0;
    busy      = (state == RUN);
    done      = (state == FIN);
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (iter) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FIN;
            wr_sc     = 1'b1;
          end
        end
      end
      // The last step and the result write share one edge.
      RUN: begin
        if (cnt == CW'(1)) begin
          state_nxt = FIN;
          wr_it     = 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  // NOTE: operand/working registers carry no reset; they are always loaded at
  // start before being read, and only the FSM and visible outputs need one.
  always_ff @(posedge clk) begin
    if (load) begin
      op_q <= op;
      cnt  <= is_shift ? {1'b0, amt} : CW'(WIDTH);
      if (is_mul) begin
        work   <= {{WIDTH{1'b0}}, b};
        opnd_q <= a;
      end else begin
        work   <= {{WIDTH{1'b0}}, a};
        opnd_q <= b;
      end
    end else if (state == RUN) begin
      work <= step_work;
      cnt  <= cnt - CW'(1);
    end
  end

  // Visible result and flags: change only on entry to FIN or on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (wr_sc || wr_it) begin
      result   <= fin_res;
      carry    <= fin_c;
      zero     <= (fin_res == '0);
      negative <= fin_res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- scoreboard bench for seq_alu (WIDTH=8 main instance plus a
// WIDTH=16 instance for the single-cycle ops). Expected results come from a
// behavioural model built on native operators and are queued when an op is
// started, then popped and compared when done is observed.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        n;
    logic        z;
    logic        c;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, start, start16;
  logic [4:0]  op, op16;
  logic [7:0]  a, b, result;
  logic [15:0] a16, b16, result16;
  logic        busy, done, carry, zero, negative;
  logic        busy16, done16, carry16, zero16, negative16;

  exp_t sb[$];
  logic mc, mc16;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .negative(negative)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .carry(carry16),
    .zero(zero16), .negative(negative16)
  );

  // Behavioural reference for width w (8 or 16).
  function automatic exp_t model(input int w, input logic [4:0] o,
                                 input logic [63:0] x, input logic [63:0] y,
                                 input logic cin);
    exp_t               e;
    logic [63:0]        mask, s, p;
    logic signed [63:0] sx;
    int                 amt;
    mask = (64'd1 << w) - 64'd1;
    amt  = int'(y & 64'(w - 1));
    e = '0;
    e.lat = 8'd1;
    p = x * y;
    s = '0;
    sx = '0;
    case (o)
      5'd0: s = x;
      5'd1: s = y;
      5'd2: begin s = x + y;                 e.c = s[w]; end
      5'd3: begin s = x + y + {63'd0, cin};  e.c = s[w]; end
      5'd4: begin s = x - y;                 e.c = (x < y); end
      5'd5: begin s = x - y - {63'd0, cin};  e.c = (x < y + {63'd0, cin}); end
      5'd6: s = x & y;
      5'd7: s = x | y;
      5'd8: s = x ^ y;
      5'd9: s = ~x;
      5'd10: begin s = x << amt;  e.c = (amt != 0) && x[w-amt]; end
      5'd11: begin s = x >> amt;  e.c = (amt != 0) && x[amt-1]; end
      5'd12: begin
        sx  = x[w-1] ? signed'(x | ~mask) : signed'(x);
        s   = 64'(sx >>> amt);
        e.c = (amt != 0) && x[amt-1];
      end
      5'd13: begin
        s   = ((x << amt) | (x >> (w - amt))) & mask;
        e.c = (amt != 0) && s[0];
      end
      5'd14: begin s = p;       e.c = ((p >> w) != 0); e.lat = 8'(w + 1); end
      5'd15: begin s = p >> w;                         e.lat = 8'(w + 1); end
`ifdef SEQ_ALU_DIV_EN
      5'd16, 5'd17: begin
        e.lat = 8'(w + 1);
        if (y == 0) begin
          s   = (o == 5'd16) ? mask : x;
          e.c = 1'b1;
        end else begin
          s = (o == 5'd16) ? (x / y) : (x % y);
        end
      end
`endif
      default: s = '0;
    endcase
    if (o >= 5'd10 && o <= 5'd13 && amt != 0) e.lat = 8'(amt + 1);
    s     = s & mask;
    e.res = s[31:0];
    e.z   = (s == 0);
    e.n   = s[w-1];
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("res=%0h nzc=%b%b%b lat=%0d", e.res, e.n, e.z, e.c, e.lat);
  endfunction

  // Drive one start pulse on the 8-bit DUT and queue its expectation.
  // Returns at the negedge after the start edge (latency 1 point).
  task automatic issue(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e  = model(8, o, {56'd0, x}, {56'd0, y}, mc);
    mc = e.c;
    sb.push_back(e);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; n0 is the latency already elapsed on entry.
  task automatic wait_done(output exp_t obs, input int n0);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    obs.res = {24'd0, result};
    obs.n   = negative;
    obs.z   = zero;
    obs.c   = carry;
    obs.lat = (done === 1'b1) ? 8'(n) : 8'hFF;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int   dn;
    reset_n = 1'b0; start = 1'b0; start16 = 1'b0;
    op = '0; a = '0; b = '0; op16 = '0; a16 = '0; b16 = '0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({result, negative, zero, carry, busy, done} !== 13'd0)
      $display("FAIL reset_state: got res=%h nzc=%b%b%b busy=%b done=%b, want all 0",
               result, negative, zero, carry, busy, done);
    else passed++;
    reset_n = 1'b1; mc = 1'b0; mc16 = 1'b0;

    issue(5'd2, 8'h12, 8'h34);
    wait_done(o, 1);
    e = sb.pop_front();
    total++;
    if (o !== e) $display("FAIL pre_abort_add: got %s, want %s", fmt(o), fmt(e));
    else passed++;

    // Abort MULLO in its 4th RUN cycle.
    issue(5'd14, 8'h0F, 8'h11);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_in_run: got %b, want 1", busy);
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, result} !== 10'd0)
      $display("FAIL abort_state: got busy=%b done=%b res=%h, want 0 0 00", busy, done, result);
    else passed++;
    reset_n = 1'b1; mc = 1'b0; mc16 = 1'b0;
    void'(sb.pop_back());
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    total++;
    if (dn !== 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", dn);
    else passed++;
  endtask

  task automatic test_arith();
    logic [4:0] to[10] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd1};
    logic [7:0] ta[10] = '{8'hFF, 8'h00, 8'h10, 8'h80, 8'hF0, 8'hF0, 8'hF0, 8'h5A, 8'h3C, 8'h3C};
    logic [7:0] tb[10] = '{8'h01, 8'h00, 8'h20, 8'h7F, 8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hC3};
    exp_t obs[10];
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(obs[i], 1);
      e = sb.pop_front();
      total++;
      if (obs[i] !== e)
        $display("FAIL arith op=%0d a=%h b=%h: got %s, want %s", to[i], ta[i], tb[i], fmt(obs[i]), fmt(e));
      else passed++;
    end
    total++;
    if ({obs[0].res[7:0], obs[0].n, obs[0].z, obs[0].c, obs[0].lat} !== {8'h00, 3'b011, 8'd1})
      $display("FAIL add_ff_01: got %s, want res=0 nzc=011 lat=1", fmt(obs[0]));
    else passed++;
    total++;
    if ({obs[1].res[7:0], obs[1].c} !== {8'h01, 1'b0})
      $display("FAIL adc_chain: got %s, want res=1 c=0", fmt(obs[1]));
    else passed++;
    total++;
    if ({obs[2].res[7:0], obs[2].n, obs[2].z, obs[2].c} !== {8'hF0, 3'b101})
      $display("FAIL sub_borrow: got %s, want res=f0 nzc=101", fmt(obs[2]));
    else passed++;
  endtask

  task automatic test_shift();
    logic [4:0] to[6] = '{5'd10, 5'd12, 5'd13, 5'd11, 5'd13, 5'd10};
    logic [7:0] ta[6] = '{8'h81, 8'h80, 8'h81, 8'h81, 8'h81, 8'h01};
    logic [7:0] tb[6] = '{8'h03, 8'h07, 8'h00, 8'h01, 8'h07, 8'h07};
    exp_t obs[6];
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(obs[i], 1);
      e = sb.pop_front();
      total++;
      if (obs[i] !== e)
        $display("FAIL shift op=%0d a=%h b=%h: got %s, want %s", to[i], ta[i], tb[i], fmt(obs[i]), fmt(e));
      else passed++;
    end
    total++;
    if ({obs[0].res[7:0], obs[0].c, obs[0].lat} !== {8'h08, 1'b0, 8'd4})
      $display("FAIL shl_81_3: got %s, want res=8 c=0 lat=4", fmt(obs[0]));
    else passed++;
    total++;
    if ({obs[1].res[7:0], obs[1].n, obs[1].c} !== {8'hFF, 1'b1, 1'b0})
      $display("FAIL asr_80_7: got %s, want res=ff n=1 c=0", fmt(obs[1]));
    else passed++;
    total++;
    if ({obs[2].res[7:0], obs[2].c, obs[2].lat} !== {8'h81, 1'b0, 8'd1})
      $display("FAIL rol_amt0: got %s, want res=81 c=0 lat=1", fmt(obs[2]));
    else passed++;
  endtask

  task automatic test_mul();
    exp_t o, e;
    int   dn;
    issue(5'd14, 8'h0F, 8'h11);
    wait_done(o, 1);
    e = sb.pop_front();
    total++;
    if (o !== e || {o.res[7:0], o.c, o.lat} !== {8'hFF, 1'b0, 8'd9})
      $display("FAIL mullo_0f_11: got %s, want %s", fmt(o), fmt(e));
    else passed++;

    issue(5'd15, 8'hFF, 8'hFF);
    wait_done(o, 1);
    e = sb.pop_front();
    total++;
    if (o !== e || o.res[7:0] !== 8'hFE)
      $display("FAIL mulhi_ff_ff: got %s, want %s", fmt(o), fmt(e));
    else passed++;

    // start pulsed while busy must be ignored.
    issue(5'd14, 8'h0F, 8'h0F);
    @(negedge clk);
    op = 5'd2; a = 8'h01; b = 8'h01; start = 1'b1;
    total++;
    if (result !== 8'hFE) $display("FAIL hold_while_busy: got %h, want fe", result);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    wait_done(o, 3);
    e = sb.pop_front();
    total++;
    if (o !== e) $display("FAIL start_while_busy: got %s, want %s", fmt(o), fmt(e));
    else passed++;

    // start held during FIN must also be ignored.
    op = 5'd0; a = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    total++;
    if (dn !== 0 || result !== 8'hE1)
      $display("FAIL start_in_fin: got %0d dones res=%h, want 0 dones res=e1", dn, result);
    else passed++;
  endtask

  task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
    logic [4:0] to[4] = '{5'd16, 5'd17, 5'd16, 5'd17};
    logic [7:0] ta[4] = '{8'hC8, 8'hC8, 8'h05, 8'h05};
    logic [7:0] tb[4] = '{8'h07, 8'h07, 8'h00, 8'h00};
    logic [7:0] want_res[4] = '{8'h1C, 8'h04, 8'hFF, 8'h05};
    logic       want_c[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] want_lat    = 8'd9;
`else
    logic [4:0] to[4] = '{5'd16, 5'd17, 5'd16, 5'd17};
    logic [7:0] ta[4] = '{8'hC8, 8'hC8, 8'h05, 8'h05};
    logic [7:0] tb[4] = '{8'h07, 8'h07, 8'h00, 8'h00};
    logic [7:0] want_res[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic       want_c[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] want_lat    = 8'd1;
`endif
    exp_t o, e;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(o, 1);
      e = sb.pop_front();
      total++;
      if (o !== e || {o.res[7:0], o.c, o.lat} !== {want_res[i], want_c[i], want_lat})
        $display("FAIL div op=%0d a=%h b=%h: got %s, want res=%h c=%b lat=%0d",
                 to[i], ta[i], tb[i], fmt(o), want_res[i], want_c[i], want_lat);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t       o, e;
    logic [7:0] x, y;
    for (int oi = 0; oi < 32; oi++) begin
      for (int k = 0; k < 20; k++) begin
        case (k)
          0: begin x = 8'h00; y = 8'h00; end
          1: begin x = 8'hFF; y = 8'hFF; end
          2: begin x = 8'hFF; y = 8'h01; end
          3: begin x = 8'h80; y = 8'h07; end
          default: begin x = 8'($urandom); y = 8'($urandom); end
        endcase
        issue(5'(oi), x, y);
        wait_done(o, 1);
        e = sb.pop_front();
        total++;
        if (o !== e)
          $display("FAIL sweep op=%0d a=%h b=%h: got %s, want %s", oi, x, y, fmt(o), fmt(e));
        else passed++;
      end
    end
  endtask

  task automatic test_width16();
    exp_t        o, e;
    logic [15:0] x, y;
    int          n;
    for (int oi = 0; oi < 32; oi++) begin
      if (oi == 14 || oi == 15) continue;
`ifdef SEQ_ALU_DIV_EN
      if (oi == 16 || oi == 17) continue;
`endif
      for (int k = 0; k < 12; k++) begin
        x = 16'($urandom);
        y = 16'($urandom);
        if (oi >= 10 && oi <= 13) y = y & 16'hFFF0;
        e    = model(16, 5'(oi), {48'd0, x}, {48'd0, y}, mc16);
        mc16 = e.c;
        sb.push_back(e);
        @(negedge clk);
        op16 = 5'(oi); a16 = x; b16 = y; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (done16 !== 1'b1 && n < 40) begin
          @(negedge clk);
          n++;
        end
        o.res = {16'd0, result16};
        o.n   = negative16;
        o.z   = zero16;
        o.c   = carry16;
        o.lat = (done16 === 1'b1) ? 8'(n) : 8'hFF;
        e = sb.pop_front();
        total++;
        if (o !== e)
          $display("FAIL w16 op=%0d a=%h b=%h: got %s, want %s", oi, x, y, fmt(o), fmt(e));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_div();
    test_back_to_back();
    test_width16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
